// File: rtl/qc_syndrome_encoder.sv
// -----------------------------------------------------------------------------
// qc_syndrome_encoder
//
// Transmit-side syndrome encoder for QC-LDPC key reconciliation. A sifted-key
// frame arrives as NB_COL circulant-wide words, one per block column. Each word
// is folded into the NB_ROW syndrome words, one block row per cycle. The
// syndrome s = H*x over GF(2) is then streamed out as NB_ROW words.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_data    key word for the current block column (CIRC bits)
//   in_valid   in_data valid
//   in_last    marks the final key word of a frame (checked, never obeyed)
//   in_ready   block accepts in_data (only in LOAD)
//   out_data   syndrome word (CIRC bits), held stable until out_ready
//   out_valid  out_data valid
//   out_last   marks the final syndrome word (row NB_ROW-1)
//   out_ready  downstream accepts out_data
//   frame_err  in_last misaligned in the current frame; sticky until the
//              first beat of the next frame
//
// SHIFT_TABLE: entry e = i*NB_COL + j sits at [e*(LOG2CIRC+1) +: LOG2CIRC+1].
// Entry MSB set = all-zero block; otherwise the low bits are the shift s and
// block row r has its single 1 at column (r+s) mod CIRC.
// -----------------------------------------------------------------------------
module qc_syndrome_encoder #(
    parameter int CIRC     = 4,
    parameter int LOG2CIRC = 2,
    parameter int NB_ROW   = 3,
    parameter int NB_COL   = 6,
    // Listed from entry 17 (row2,col5) down to entry 0 (row0,col0); 4 = null.
    parameter logic [NB_ROW*NB_COL*(LOG2CIRC+1)-1:0] SHIFT_TABLE = {
        3'd3, 3'd2, 3'd4, 3'd0, 3'd4, 3'd1,   // row 2
        3'd0, 3'd3, 3'd2, 3'd1, 3'd0, 3'd4,   // row 1
        3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0    // row 0
    }
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CIRC-1:0] in_data,
    input  logic            in_valid,
    input  logic            in_last,
    output logic            in_ready,
    output logic [CIRC-1:0] out_data,
    output logic            out_valid,
    output logic            out_last,
    input  logic            out_ready,
    output logic            frame_err
);

    localparam int ENT_W   = LOG2CIRC + 1;
    localparam int TBL_W   = NB_ROW * NB_COL * ENT_W;
    localparam int TIDX_W  = (TBL_W > 1) ? $clog2(TBL_W) : 1;
    localparam int ROW_W   = (NB_ROW > 1) ? $clog2(NB_ROW) : 1;
    localparam int COL_W   = (NB_COL > 1) ? $clog2(NB_COL) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NB_ROW - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NB_COL - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        ACCUM  = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                rst_sync;
    logic [CIRC-1:0]     x_q;
    logic [CIRC-1:0]     synd [NB_ROW];
    logic [ROW_W-1:0]    row_cnt;
    logic [COL_W-1:0]    col_cnt;
    logic [ROW_W-1:0]    out_idx;

    logic                in_hs;
    logic                out_hs;
    logic [TIDX_W-1:0]   tbl_base;
    logic [ENT_W-1:0]    blk_ent;
    logic [LOG2CIRC-1:0] rot_idx;
    logic [CIRC-1:0]     contrib;

    // Reset release is re-timed through one flop so the core leaves reset on
    // a clock edge; assertion still propagates asynchronously through it. The
    // IDLE cycle then puts in_ready high on the second edge after release.
    // NOTE: sequential state is written with <= only, so every flop samples
    // the pre-edge value of every other flop regardless of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 1'b0;
        else      rst_sync <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Circulant contribution of the held key word to block row row_cnt.
    // Bit r picks x[(r+s) mod CIRC]; the LOG2CIRC-bit add wraps modulo CIRC.
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch can be inferred.
    always_comb begin
        tbl_base = TIDX_W'((int'(row_cnt) * NB_COL + int'(col_cnt)) * ENT_W);
        blk_ent  = SHIFT_TABLE[tbl_base +: ENT_W];
        contrib  = '0;
        rot_idx  = '0;
        if (!blk_ent[ENT_W-1]) begin
            for (int r = 0; r < CIRC; r++) begin
                rot_idx    = LOG2CIRC'(r) + blk_ent[LOG2CIRC-1:0];
                contrib[r] = x_q[rot_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ACCUM;
            end
            ACCUM: begin
                if (row_cnt == ROW_LAST)
                    state_d = (col_cnt == COL_LAST) ? OUTPUT : LOAD;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                out_data  = synd[out_idx];
                out_last  = (out_idx == ROW_LAST);
                if (out_ready && (out_idx == ROW_LAST)) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Datapath: key word hold, syndrome accumulation, counters, frame check
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            x_q       <= '0;
            row_cnt   <= '0;
            col_cnt   <= '0;
            out_idx   <= '0;
            frame_err <= 1'b0;
            // NOTE: the syndrome array is only NB_ROW words of flops, so it
            // is reset explicitly; a partial frame must never leak into the
            // next one after a mid-frame reset.
            for (int i = 0; i < NB_ROW; i++) synd[i] <= '0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_hs) begin
                        x_q     <= in_data;
                        row_cnt <= '0;
                        // Frame length is set by col_cnt alone; in_last is
                        // only compared against it. First beat restarts the
                        // sticky error.
                        frame_err <= ((col_cnt == '0) ? 1'b0 : frame_err)
                                   | (in_last != (col_cnt == COL_LAST));
                    end
                end
                ACCUM: begin
                    synd[row_cnt] <= synd[row_cnt] ^ contrib;
                    if (row_cnt != ROW_LAST) begin
                        row_cnt <= row_cnt + ROW_W'(1);
                    end else if (col_cnt != COL_LAST) begin
                        col_cnt <= col_cnt + COL_W'(1);
                    end
                end
                OUTPUT: begin
                    if (out_hs) begin
                        if (out_idx == ROW_LAST) begin
                            for (int i = 0; i < NB_ROW; i++) synd[i] <= '0;
                            col_cnt <= '0;
                            out_idx <= '0;
                        end else begin
                            out_idx <= out_idx + ROW_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qc_syndrome_encoder.sv
// -----------------------------------------------------------------------------
// tb_qc_syndrome_encoder
//
// Scoreboard bench for qc_syndrome_encoder with the default 3x6 base matrix.
// Expected syndrome words are pushed when a frame is driven (fixed constants
// for the hand-worked frames, a GF(2) reference model otherwise) and popped by
// a monitor at every output handshake. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_qc_syndrome_encoder;

    localparam int CIRC   = 4;
    localparam int NB_ROW = 3;
    localparam int NB_COL = 6;

    typedef struct packed {
        logic [CIRC-1:0] data;
        logic            last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CIRC-1:0] in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_last = 1'b0;
    logic            in_ready;
    logic [CIRC-1:0] out_data;
    logic            out_valid;
    logic            out_last;
    logic            out_ready = 1'b1;
    logic            frame_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t            exp_q [$];
    exp_t            exp_e;
    logic [CIRC-1:0] frame_w  [NB_COL];
    int              hs_cyc   [NB_COL];
    logic            fe_after [NB_COL];

    // Reference base matrix, written out row by row; 4 marks a null block.
    int tbl [NB_ROW][NB_COL] = '{'{0, 1, 2, 3, 4, 4},
                                 '{4, 0, 1, 2, 3, 0},
                                 '{1, 4, 0, 4, 2, 3}};

    qc_syndrome_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL syndrome_unexpected: got data=%b last=%b, required no output", out_data, out_last);
            end else begin
                exp_e = exp_q.pop_front();
                if ({out_data, out_last} !== {exp_e.data, exp_e.last}) begin
                    errors++;
                    $display("FAIL syndrome_word: got data=%b last=%b, required data=%b last=%b",
                             out_data, out_last, exp_e.data, exp_e.last);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // GF(2) reference: synd[i] bit r ^= x_j[(r+s) mod CIRC] for non-null blocks.
    function automatic void push_model();
        exp_t e;
        for (int i = 0; i < NB_ROW; i++) begin
            e.data = '0;
            for (int j = 0; j < NB_COL; j++)
                if (tbl[i][j] != 4)
                    for (int r = 0; r < CIRC; r++)
                        e.data[r] = e.data[r] ^ frame_w[j][(r + tbl[i][j]) % CIRC];
            e.last = (i == NB_ROW - 1);
            exp_q.push_back(e);
        end
    endfunction

    task automatic random_frame();
        for (int j = 0; j < NB_COL; j++) frame_w[j] = CIRC'($urandom_range(0, 15));
    endtask

    // Drive beats first..NB_COL-1 of frame_w, keeping in_valid high between
    // beats. Records the handshake cycle of each beat and frame_err just after.
    task automatic drive_frame(input int first, input int last_pos);
        int n;
        for (int b = first; b < NB_COL; b++) begin
            @(posedge clk); #1;
            if (b > first) fe_after[b-1] = frame_err;
            in_valid = 1'b1;
            in_data  = frame_w[b];
            in_last  = (b == last_pos);
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL beat_accept: beat %0d got in_ready=0 for %0d cycles, required 1", b, n);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            hs_cyc[b] = cyc;
        end
        @(posedge clk); #1;
        fe_after[NB_COL-1] = frame_err;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain(input bit rnd);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        out_ready = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d words pending after %0d cycles, required 0", exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        int m;
        int n;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        checks++; if (out_last !== 1'b0)  begin errors++; $display("FAIL reset_out_last: got %b required 0", out_last); end
        checks++; if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data: got %b required 0000", out_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b required 0", frame_err); end

        @(posedge clk); #1;
        rst = 1'b1;
        m = cyc;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready && n < 10);
        checks++;
        if (!in_ready || cyc != m + 2) begin
            errors++;
            $display("FAIL release_in_ready: got in_ready=%b after %0d clocks, required 1 after 2", in_ready, cyc - m);
        end

        // Start a frame, flag an early in_last, then reset in the middle of
        // accumulating the second beat.
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 4'hF; in_last = 1'b1;
        @(posedge clk); #1;
        in_last = 1'b0; in_data = 4'hA;
        checks++;
        if (frame_err !== 1'b1) begin errors++; $display("FAIL early_last_err: got %b required 1", frame_err); end
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready && n < 10);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL abort_in_ready: got %b required 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b required 0", out_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL abort_frame_err: got %b required 0", frame_err); end

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        m = cyc;
        n = 0;
        do begin @(negedge clk); n++; end while (!in_ready && n < 10);
        checks++;
        if (!in_ready || cyc != m + 2) begin
            errors++;
            $display("FAIL abort_release: got in_ready=%b after %0d clocks, required 1 after 2", in_ready, cyc - m);
        end
    endtask

    task automatic test_unit_vector();
        frame_w = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        exp_q.push_back('{4'b0001, 1'b0});
        exp_q.push_back('{4'b0000, 1'b0});
        exp_q.push_back('{4'b1000, 1'b1});
        drive_frame(0, NB_COL - 1);
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL unit_frame_err: got %b required 0", frame_err); end
        wait_drain(1'b0);
    endtask

    task automatic test_all_ones();
        for (int j = 0; j < NB_COL; j++) frame_w[j] = 4'b1111;
        exp_q.push_back('{4'b0000, 1'b0});
        exp_q.push_back('{4'b1111, 1'b0});
        exp_q.push_back('{4'b0000, 1'b1});
        drive_frame(0, NB_COL - 1);
        wait_drain(1'b0);
    endtask

    task automatic test_backpressure();
        int n;
        int oc;
        int t3;
        int tin;
        @(posedge clk); #1;
        out_ready = 1'b0;
        frame_w = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        exp_q.push_back('{4'b0001, 1'b0});
        exp_q.push_back('{4'b0000, 1'b0});
        exp_q.push_back('{4'b1000, 1'b1});
        drive_frame(0, NB_COL - 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 20);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 4'b0001 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d got valid=%b data=%b last=%b, required valid=1 data=0001 last=0",
                         k, out_valid, out_data, out_last);
            end
        end

        // Release with the next frame's first beat already offered.
        random_frame();
        push_model();
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1; in_data = frame_w[0]; in_last = 1'b0;
        n = 0; oc = 0; t3 = -1; tin = -1;
        while (tin < 0 && n < 30) begin
            @(negedge clk);
            n++;
            if (out_valid && out_ready) begin
                oc++;
                if (oc == 3) t3 = cyc;
            end
            if (in_ready) tin = cyc;
        end
        checks++;
        if (oc != 3 || t3 < 0 || tin != t3 + 1) begin
            errors++;
            $display("FAIL next_frame_gate: got %0d output handshakes, in_ready at cycle %0d, required 3 and cycle %0d",
                     oc, tin, t3 + 1);
        end
        drive_frame(1, NB_COL - 1);
        wait_drain(1'b0);
    endtask

    task automatic test_misaligned();
        random_frame();
        push_model();
        drive_frame(0, 2);
        for (int b = 0; b < NB_COL; b++) begin
            checks++;
            if (fe_after[b] !== (b >= 2)) begin
                errors++;
                $display("FAIL misaligned_err: after beat %0d got frame_err=%b, required %b", b, fe_after[b], (b >= 2));
            end
        end
        wait_drain(1'b0);
        checks++;
        if (frame_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b required 1", frame_err); end

        random_frame();
        push_model();
        drive_frame(0, NB_COL - 1);
        checks++;
        if (fe_after[0] !== 1'b0) begin errors++; $display("FAIL err_clear: got %b required 0", fe_after[0]); end
        wait_drain(1'b0);
    endtask

    task automatic test_throughput();
        int n;
        random_frame();
        push_model();
        drive_frame(0, NB_COL - 1);
        for (int b = 1; b < NB_COL; b++) begin
            checks++;
            if (hs_cyc[b] - hs_cyc[b-1] != NB_ROW + 1) begin
                errors++;
                $display("FAIL beat_spacing: beat %0d got %0d cycles, required %0d", b, hs_cyc[b] - hs_cyc[b-1], NB_ROW + 1);
            end
        end
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!out_valid || cyc - hs_cyc[NB_COL-1] != NB_ROW + 1) begin
            errors++;
            $display("FAIL latency: got out_valid=%b at %0d cycles, required 1 at %0d",
                     out_valid, cyc - hs_cyc[NB_COL-1], NB_ROW + 1);
        end
        wait_drain(1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            random_frame();
            push_model();
            drive_frame(0, NB_COL - 1);
            wait_drain(1'b1);
        end
    endtask

    initial begin
        rst = 1'b1;
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_unit_vector();
        test_all_ones();
        test_backpressure();
        test_misaligned();
        test_throughput();
        test_random();
        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qc_syndrome_encoder.md
Name: qc_syndrome_encoder

Overview:
- Transmit-side (Alice) counterpart to the QC-LDPC reconciliation decoder.
- Accepts a sifted-key frame as a stream of circulant-wide words, one per block column.
- Computes the syndrome s = H·x over GF(2) using the quasi-cyclic base matrix.
- Streams NB_ROW syndrome words out for transmission to the decoder side.

Parameters:
- CIRC, 4, circulant size in bits (input/output word width).
- LOG2CIRC, 2, bits of a circulant shift value.
- NB_ROW, 3, block rows of H (syndrome words per frame).
- NB_COL, 6, block columns of H (key words per frame).
- SHIFT_TABLE, see Behaviour, flattened base matrix, NB_ROW*NB_COL entries of LOG2CIRC+1 bits each.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, asynchronous active-low reset.
- in_data, in, CIRC, key word for the current block column.
- in_valid, in, 1, in_data valid.
- in_last, in, 1, marks the final key word of a frame.
- in_ready, out, 1, block accepts in_data.
- out_data, out, CIRC, syndrome word.
- out_valid, out, 1, out_data valid.
- out_last, out, 1, marks the final syndrome word (row NB_ROW-1).
- out_ready, in, 1, downstream accepts out_data.
- frame_err, out, 1, in_last misaligned in the current frame; sticky until the next frame starts.

Behaviour:
- **SHIFT_TABLE layout:** entry e = i*NB_COL + j occupies bits [e*(LOG2CIRC+1) +: LOG2CIRC+1].
  - Entry MSB = 1 means an all-zero block.
  - Otherwise the low LOG2CIRC bits give shift s.
  - Block row r has a single 1 at column (r+s) mod CIRC.
- **Default table (rows i=0..2, cols j=0..5, value 4 = null):**
  - row0: 0,1,2,3,4,4
  - row1: 4,0,1,2,3,0
  - row2: 1,4,0,4,2,3
- **Contribution of a word:** block (i,j) adds to synd[i] bit r the value x_j[(r+s) mod CIRC]. Null blocks add 0. Accumulation is XOR.
- **Reset (rst=0):**
  - state=IDLE; synd[*]=0; col_cnt=0, row_cnt=0, out_idx=0.
  - in_ready=0, out_valid=0, out_last=0, out_data=0, frame_err=0.
- **FSM:**
  - IDLE: next cycle goes to LOAD.
  - LOAD:
    - in_ready=1.
    - On in_valid&&in_ready, register in_data, set row_cnt=0, go to ACCUM.
    - If col_cnt==0, clear frame_err at this handshake.
    - in_last on a beat with col_cnt!=NB_COL-1 sets frame_err.
    - in_last absent on col_cnt==NB_COL-1 also sets frame_err.
    - Frame length is fixed by col_cnt; in_last never truncates or extends a frame.
  - ACCUM:
    - in_ready=0, one block row per cycle: synd[row_cnt] ^= contribution, row_cnt++.
    - After row NB_ROW-1: if col_cnt==NB_COL-1 go to OUTPUT, else col_cnt++ and go to LOAD.
    - Each input beat costs NB_ROW+1 cycles, giving a maximum input rate of 1 beat per NB_ROW+1 cycles.
  - OUTPUT:
    - out_valid=1, out_data=synd[out_idx], out_last=(out_idx==NB_ROW-1).
    - out_data is held stable until out_ready.
    - On out_valid&&out_ready, out_idx++.
    - After the last word: clear synd, col_cnt=0, out_idx=0, go to LOAD (out_valid=0 the next cycle).
- **Latency:** first out_valid occurs NB_ROW+1 cycles after the handshake of the final key word.
- **Backpressure:** out_ready low stalls in OUTPUT indefinitely with no data loss. in_valid is ignored outside LOAD.
- **Reset mid-frame:** partial syndrome is discarded, and all registers return to reset values immediately (asynchronous).

Test Plan:
- **Reset:** rst low mid-ACCUM.
  - in_ready=0, out_valid=0, frame_err=0 immediately.
  - in_ready=1 exactly two clocks after rst rises.
- **Unit vector:** x0=4'b0001, x1..x5=0, in_last on beat 5.
  - Outputs in order: 0001, 0000, 1000; out_last only on the third word.
  - frame_err=0.
- **All-ones frame:** every x_j=4'b1111.
  - Outputs: row0 (4 non-null) 0000, row1 (5 non-null) 1111, row2 (4 non-null) 0000.
- **Backpressure:**
  - Hold out_ready=0 for 10 cycles: out_data stays 0001 and out_valid stays 1.
  - Then release: words 0001, 0000, 1000 complete with no drop.
  - The next frame is accepted only after the third output handshake.
- **Misaligned in_last:** in_last on beat 2.
  - frame_err=1 from the cycle after beat 2 and held.
  - Syndrome is still computed over all 6 beats.
  - frame_err clears on the first beat of the next frame.
- **Throughput:** in_valid held high for 6 beats.
  - in_ready pulses once every NB_ROW+1=4 cycles.
  - First out_valid appears 4 cycles after the 6th handshake.
